// File: rtl/sudoku_game_ctrl_pkg.sv
// Shared state codes, state type and phase-flag bundle for the Sudoku game controller.
package sudoku_pkg;

    typedef logic [3:0] state_t;

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_GEN_RAND   = 4'd1;
    localparam logic [3:0] ST_SET_BOARD  = 4'd2;
    localparam logic [3:0] ST_SET_DIFF   = 4'd3;
    localparam logic [3:0] ST_CHOOSE_ROW = 4'd4;
    localparam logic [3:0] ST_CHOOSE_COL = 4'd5;
    localparam logic [3:0] ST_CHOOSE_VAL = 4'd6;
    localparam logic [3:0] ST_CHECKING   = 4'd7;
    localparam logic [3:0] ST_WAIT       = 4'd8;
    localparam logic [3:0] ST_WIN        = 4'd9;
    localparam logic [3:0] ST_NEW_GAME   = 4'd10;
    localparam logic [3:0] ST_LOSE       = 4'd11;

    typedef struct packed {
        logic gen_rand;
        logic set_board;
        logic set_diff;
        logic row;
        logic col;
        logic val;
        logic check;
    } sudoku_flags_t;

    function automatic sudoku_flags_t decode_flags(input state_t s);
        sudoku_flags_t f;
        f           = '0;
        f.gen_rand  = (s == ST_GEN_RAND);
        f.set_board = (s == ST_SET_BOARD);
        f.set_diff  = (s == ST_SET_DIFF);
        f.row       = (s == ST_CHOOSE_ROW);
        f.col       = (s == ST_CHOOSE_COL);
        f.val       = (s == ST_CHOOSE_VAL);
        f.check     = (s == ST_CHECKING);
        return f;
    endfunction

endpackage

// File: rtl/sudoku_game_ctrl_btn_edge.sv
// Rising-edge detector for a level button; the edge is combinational on the current sample.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic btn_q;

    always_ff @(posedge clk) begin
        if (rst) btn_q <= 1'b0;
        else     btn_q <= btn;
    end

    assign rise = btn & ~btn_q;

endmodule

// File: rtl/sudoku_game_ctrl.sv
// Sudoku game sequencer: generation, setup, move entry, checking, mistake/timeout handling.
// Define SUDOKU_MISTAKE_LIMIT_EN to enter LOSE once mistake_count reaches MAX_MISTAKES.
module sudoku_game_ctrl
    import sudoku_pkg::*;
#(
    parameter int N             = 4,
    parameter int CW            = $clog2(N),
    parameter int VW            = $clog2(N + 1),
    parameter int MOVE_W        = 8,
    parameter int MAX_MISTAKES  = 3,
    parameter int CHECK_TIMEOUT = 15
) (
    input  logic              clka,
    input  logic              restart,
    input  logic              new_game,
    input  logic              enter,
    input  logic [CW-1:0]     row_in,
    input  logic [CW-1:0]     col_in,
    input  logic [VW-1:0]     val_in,
    input  logic              cell_locked,
    input  logic              check_done,
    input  logic              check_ok,
    input  logic              solved,
    output logic [3:0]        state,
    output logic              gen_rand_flag,
    output logic              set_board_flag,
    output logic              set_diff_flag,
    output logic              row_flag,
    output logic              col_flag,
    output logic              val_flag,
    output logic              check_flag,
    output logic              reject,
    output logic [CW-1:0]     sel_row,
    output logic [CW-1:0]     sel_col,
    output logic [VW-1:0]     sel_val,
    output logic [MOVE_W-1:0] move_count,
    output logic [3:0]        mistake_count
);

`ifdef SUDOKU_MISTAKE_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    localparam int TW = $clog2(CHECK_TIMEOUT + 1);
    localparam logic [CW:0]   N_RC      = (CW + 1)'(N);
    localparam logic [VW-1:0] N_VAL     = VW'(N);
    localparam logic [TW-1:0] WAIT_LAST = TW'(CHECK_TIMEOUT - 1);
    localparam logic [3:0]    MIST_LIM  = 4'(MAX_MISTAKES);

    logic          enter_edge;
    logic [TW-1:0] wait_cnt;
    logic [3:0]    state_nxt;
    logic          accept_row, accept_col, accept_val;
    logic          lock_rej, timeout, wrong;
    logic          go_new;
    logic [3:0]    mistake_inc;
    sudoku_flags_t flags;

    btn_edge u_enter_edge (
        .clk  (clka),
        .rst  (restart),
        .btn  (enter),
        .rise (enter_edge)
    );

    assign mistake_inc = (mistake_count == 4'hF) ? 4'hF : mistake_count + 4'd1;
    assign go_new      = new_game && (state != ST_NEW_GAME);

    always_comb begin
        state_nxt  = state;
        accept_row = 1'b0;
        accept_col = 1'b0;
        accept_val = 1'b0;
        lock_rej   = 1'b0;
        timeout    = 1'b0;
        wrong      = 1'b0;
        case (state)
            ST_IDLE:      state_nxt = ST_GEN_RAND;
            ST_GEN_RAND:  if (enter_edge) state_nxt = ST_SET_BOARD;
            ST_SET_BOARD: if (enter_edge) state_nxt = ST_SET_DIFF;
            ST_SET_DIFF:  if (enter_edge) state_nxt = ST_CHOOSE_ROW;
            ST_CHOOSE_ROW: begin
                if (enter_edge && ({1'b0, row_in} < N_RC)) begin
                    accept_row = 1'b1;
                    state_nxt  = ST_CHOOSE_COL;
                end
            end
            ST_CHOOSE_COL: begin
                if (enter_edge && ({1'b0, col_in} < N_RC)) begin
                    accept_col = 1'b1;
                    state_nxt  = ST_CHOOSE_VAL;
                end
            end
            ST_CHOOSE_VAL: begin
                // A given clue can never be overwritten, so bounce back without waiting for enter.
                if (cell_locked) begin
                    lock_rej  = 1'b1;
                    state_nxt = ST_CHOOSE_ROW;
                end else if (enter_edge && (val_in != '0) && (val_in <= N_VAL)) begin
                    accept_val = 1'b1;
                    state_nxt  = ST_CHECKING;
                end
            end
            ST_CHECKING:  state_nxt = ST_WAIT;
            ST_WAIT: begin
                // A result arriving on the last allowed cycle wins over the timeout.
                if (check_done) begin
                    if (!check_ok) begin
                        wrong     = 1'b1;
                        state_nxt = (LIMIT_EN && (mistake_inc >= MIST_LIM)) ? ST_LOSE : ST_CHOOSE_ROW;
                    end else begin
                        state_nxt = solved ? ST_WIN : ST_CHOOSE_ROW;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = ST_CHOOSE_ROW;
                end
            end
            ST_WIN:       state_nxt = ST_WIN;
            ST_LOSE:      state_nxt = ST_LOSE;
            ST_NEW_GAME:  state_nxt = ST_GEN_RAND;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            state         <= ST_IDLE;
            reject        <= 1'b0;
            sel_row       <= '0;
            sel_col       <= '0;
            sel_val       <= '0;
            move_count    <= '0;
            mistake_count <= '0;
            wait_cnt      <= '0;
        end else begin
            reject <= 1'b0;
            if (go_new) begin
                state <= ST_NEW_GAME;
            end else begin
                state <= state_nxt;
                if (accept_row) sel_row <= row_in;
                if (accept_col) sel_col <= col_in;
                if (accept_val) sel_val <= val_in;
                if (state == ST_CHECKING) begin
                    wait_cnt <= '0;
                    if (move_count != '1) move_count <= move_count + MOVE_W'(1);
                end
                // wait_cnt holds the number of WAIT cycles already spent.
                if (state == ST_WAIT) wait_cnt <= wait_cnt + TW'(1);
                if (wrong) mistake_count <= mistake_inc;
                if (lock_rej || timeout) reject <= 1'b1;
                if (state == ST_NEW_GAME) begin
                    sel_row       <= '0;
                    sel_col       <= '0;
                    sel_val       <= '0;
                    move_count    <= '0;
                    mistake_count <= '0;
                end
            end
        end
    end

    assign flags          = decode_flags(state);
    assign gen_rand_flag  = flags.gen_rand;
    assign set_board_flag = flags.set_board;
    assign set_diff_flag  = flags.set_diff;
    assign row_flag       = flags.row;
    assign col_flag       = flags.col;
    assign val_flag       = flags.val;
    assign check_flag     = flags.check;

endmodule
